// File: rtl/mareg_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mareg_ctrl_if
// Brief    : Job, operand, MAC-datapath and result signals of mareg_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface mareg_ctrl_if #(
  parameter int DATA_W = 2,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 2*DATA_W+LEN_W
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_w;
  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] mac_x;
  logic [DATA_W-1:0] mac_w;
  logic [ACC_W-1:0]  mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  modport master (
    output start, len, in_valid, in_x, in_w, mac_acc, res_ready,
    input  busy, in_ready, mac_clr, mac_en, mac_x, mac_w, res_valid, res_data
  );

  modport slave (
    input  start, len, in_valid, in_x, in_w, mac_acc, res_ready,
    output busy, in_ready, mac_clr, mac_en, mac_x, mac_w, res_valid, res_data
  );
endinterface
`default_nettype wire

// File: rtl/mareg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mareg_ctrl
// Brief    : Sequences a multiply-accumulate job over an external MAC register
//            datapath. Optional abort input enabled by MAREG_CTRL_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mareg_ctrl #(
  parameter int DATA_W  = 2,
  parameter int LEN_W   = 8,
  parameter int ACC_W   = 2*DATA_W+LEN_W,
  parameter int MAC_LAT = 1
) (
  input  wire logic    clk,
  input  wire logic    rst,
`ifdef MAREG_CTRL_ABORT_EN
  input  wire logic    abort,
`endif
  mareg_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam int              WAIT_W      = 3;
  localparam logic [WAIT_W-1:0] C_WAIT_LOAD = WAIT_W'(MAC_LAT);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mac_clr_q, mac_clr_d;
  logic                mac_en_q, mac_en_d;
  logic [DATA_W-1:0]   mac_x_q, mac_x_d;
  logic [DATA_W-1:0]   mac_w_q, mac_w_d;
  logic [ACC_W-1:0]    res_data_q, res_data_d;

  logic abort_req;
  logic in_ready_int;
  logic xfer;

`ifdef MAREG_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // abort masks in_ready so an aborted cycle never consumes an operand
  assign in_ready_int = (state_q == S_RUN) && !abort_req;
  assign xfer         = in_ready_int && bus.in_valid;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    wait_d     = wait_q;
    mac_clr_d  = 1'b0;
    mac_en_d   = 1'b0;
    mac_x_d    = mac_x_q;
    mac_w_d    = mac_w_q;
    res_data_d = res_data_q;

    if (abort_req && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      rem_d     = '0;
      wait_d    = '0;
      mac_clr_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            rem_d     = bus.len;
            mac_clr_d = 1'b1;
            state_d   = S_CLR;
          end
        end
        S_CLR: begin
          if (rem_q != '0) begin
            state_d = S_RUN;
          end else begin
            wait_d  = C_WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
        S_RUN: begin
          if (xfer) begin
            mac_x_d  = bus.in_x;
            mac_w_d  = bus.in_w;
            mac_en_d = 1'b1;
            rem_d    = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              wait_d  = C_WAIT_LOAD;
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // MAC_LAT+1 cycles here lets the final mac_en settle into mac_acc
          if (wait_q == '0) begin
            res_data_d = bus.mac_acc;
            state_d    = S_RESULT;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      wait_q     <= '0;
      mac_clr_q  <= 1'b0;
      mac_en_q   <= 1'b0;
      mac_x_q    <= '0;
      mac_w_q    <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      wait_q     <= wait_d;
      mac_clr_q  <= mac_clr_d;
      mac_en_q   <= mac_en_d;
      mac_x_q    <= mac_x_d;
      mac_w_q    <= mac_w_d;
      res_data_q <= res_data_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.in_ready  = in_ready_int;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_x     = mac_x_q;
  assign bus.mac_w     = mac_w_q;
  assign bus.res_valid = (state_q == S_RESULT);
  assign bus.res_data  = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mareg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mareg_ctrl
// Brief    : Directed bench for mareg_ctrl with a one-cycle MAC register model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mareg_ctrl;

  localparam int DATA_W  = 2;
  localparam int LEN_W   = 8;
  localparam int ACC_W   = 2*DATA_W+LEN_W;
  localparam int MAC_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef MAREG_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  mareg_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

  mareg_ctrl #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .ACC_W  (ACC_W),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef MAREG_CTRL_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus.slave)
  );

  // MAC register datapath: single-cycle accumulate
  logic [ACC_W-1:0] acc = '0;
  int n_edge = 0;
  int n_en   = 0;
  int n_clr  = 0;
  int n_cmp  = 0;
  int n_err  = 0;

  assign bus.mac_acc = acc;

  always @(posedge clk) begin
    n_edge <= n_edge + 1;
    if (bus.mac_en)  n_en  <= n_en + 1;
    if (bus.mac_clr) n_clr <= n_clr + 1;
    if (rst || bus.mac_clr) acc <= '0;
    else if (bus.mac_en)    acc <= acc + ACC_W'(bus.mac_x) * ACC_W'(bus.mac_w);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l, output int s);
    bus.len   = LEN_W'(l);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    s = n_edge;
  endtask

  task automatic send(input int x, input int w);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = DATA_W'(x);
    bus.in_w     = DATA_W'(w);
    while (!bus.in_ready && guard < 20) begin
      cyc();
      guard++;
    end
    if (guard >= 20) check_eq("send_timeout", 32'(guard), 0);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int s, output int lat);
    int guard = 0;
    while (!bus.res_valid && guard < 50) begin
      cyc();
      guard++;
    end
    if (guard >= 50) check_eq("res_timeout", 32'(guard), 0);
    lat = n_edge - s;
  endtask

  initial begin
    int s, lat, e0, c0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_w      = '0;
    bus.res_ready = 1'b1;

    repeat (3) cyc();
    check_eq("rst_busy",      32'(bus.busy),      0);
    check_eq("rst_in_ready",  32'(bus.in_ready),  0);
    check_eq("rst_mac_clr",   32'(bus.mac_clr),   0);
    check_eq("rst_mac_en",    32'(bus.mac_en),    0);
    check_eq("rst_mac_xw",    32'({bus.mac_x, bus.mac_w}), 0);
    check_eq("rst_res_valid", 32'(bus.res_valid), 0);
    check_eq("rst_res_data",  32'(bus.res_data),  0);
    rst = 1'b0;
    cyc();

    // Job 1: three pairs back-to-back, 1*1+2*3+3*3 = 16
    e0 = n_en; c0 = n_clr;
    start_job(3, s);
    check_eq("j1_busy", 32'(bus.busy), 1);
    send(1, 1); send(2, 3); send(3, 3);
    wait_res(s, lat);
    check_eq("j1_latency", 32'(lat), 6);
    check_eq("j1_res_data", 32'(bus.res_data), 16);
    check_eq("j1_mac_en_cnt", 32'(n_en - e0), 3);
    check_eq("j1_mac_clr_cnt", 32'(n_clr - c0), 1);
    check_eq("j1_mac_xw_hold", 32'({bus.mac_x, bus.mac_w}), 32'({2'd3, 2'd3}));
    cyc();
    check_eq("j1_res_valid_drop", 32'(bus.res_valid), 0);
    check_eq("j1_idle", 32'(bus.busy), 0);

    // Job 2: two stall cycles between pair 1 and pair 2
    e0 = n_en;
    start_job(3, s);
    send(1, 1);
    repeat (2) begin
      check_eq("j2_stall_ready", 32'(bus.in_ready), 1);
      cyc();
    end
    check_eq("j2_stall_no_en", 32'(n_en - e0), 1);
    send(2, 3); send(3, 3);
    wait_res(s, lat);
    check_eq("j2_latency", 32'(lat), 8);
    check_eq("j2_res_data", 32'(bus.res_data), 16);
    check_eq("j2_mac_en_cnt", 32'(n_en - e0), 3);
    cyc();

    // Job 3: empty job
    e0 = n_en; c0 = n_clr;
    start_job(0, s);
    check_eq("j3_in_ready_clr", 32'(bus.in_ready), 0);
    wait_res(s, lat);
    check_eq("j3_latency", 32'(lat), 3);
    check_eq("j3_res_data", 32'(bus.res_data), 0);
    check_eq("j3_mac_en_cnt", 32'(n_en - e0), 0);
    check_eq("j3_mac_clr_cnt", 32'(n_clr - c0), 1);
    cyc();

    // Job 4: result back-pressure, start during RESULT and on its exit edge
    bus.res_ready = 1'b0;
    start_job(1, s);
    send(3, 2);
    wait_res(s, lat);
    check_eq("j4_latency", 32'(lat), 4);
    for (int i = 0; i < 5; i++) begin
      check_eq("j4_hold", 32'({bus.res_valid, bus.res_data}), 32'({1'b1, 12'd6}));
      if (i == 2) begin
        bus.len   = LEN_W'(5);
        bus.start = 1'b1;
      end
      cyc();
      bus.start = 1'b0;
    end
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_eq("j4_exit_busy", 32'(bus.busy), 0);
    check_eq("j4_exit_valid", 32'(bus.res_valid), 0);
    cyc();
    check_eq("j4_start_ignored", 32'(bus.busy), 0);

    // Job 5: reset after one of three transfers, then a clean job (2*2+1*3 = 7)
    start_job(3, s);
    send(1, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("j5_rst_busy",  32'(bus.busy), 0);
    check_eq("j5_rst_ready", 32'(bus.in_ready), 0);
    check_eq("j5_rst_en",    32'(bus.mac_en), 0);
    check_eq("j5_rst_xw",    32'({bus.mac_x, bus.mac_w}), 0);
    check_eq("j5_rst_res",   32'({bus.res_valid, bus.res_data}), 0);
    cyc();
    e0 = n_en;
    start_job(2, s);
    send(2, 2); send(1, 3);
    wait_res(s, lat);
    check_eq("j5_latency", 32'(lat), 5);
    check_eq("j5_res_data", 32'(bus.res_data), 7);
    check_eq("j5_mac_en_cnt", 32'(n_en - e0), 2);
    cyc();

`ifdef MAREG_CTRL_ABORT_EN
    // Abort while waiting for the datapath
    start_job(2, s);
    send(1, 1); send(2, 2);
    abort = 1'b1;
    c0 = n_clr;
    cyc();
    abort = 1'b0;
    check_eq("ab_wait_busy", 32'(bus.busy), 0);
    check_eq("ab_wait_clr", 32'(bus.mac_clr), 1);
    repeat (4) begin
      check_eq("ab_no_result", 32'(bus.res_valid), 0);
      cyc();
    end
    check_eq("ab_clr_cnt", 32'(n_clr - c0), 1);

    // Abort in RUN with an operand offered
    start_job(1, s);
    cyc();
    e0 = n_en;
    bus.in_valid = 1'b1;
    bus.in_x     = 2'd3;
    bus.in_w     = 2'd3;
    abort        = 1'b1;
    check_eq("ab_run_ready", 32'(bus.in_ready), 0);
    cyc();
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("ab_run_busy", 32'(bus.busy), 0);
    cyc();
    check_eq("ab_run_no_en", 32'(n_en - e0), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
